// File: rtl/volatility_window_stats.sv
// ---------------------------------------------------------------------------
// volatility_window_stats
//   Per-stock sliding-window price store with incrementally maintained
//   running sum and sum-of-squares. When a stock's window is full, each new
//   sample produces N*sum(p^2) - (sum p)^2, which is N^2 times the population
//   variance. This avoids a divider.
//
//   Pipeline:
//     E0  register the sample and read the evicted price at i_wr_addr
//     E1  update sum/sumsq/count, write the new price into the window
//     E2  register the statistics outputs
//
// Ports
//   i_clk, i_reset_n  clock and synchronous active-low reset
//   i_wr_valid        one sample per cycle, no backpressure
//   i_stock_id        stock of the sample
//   i_wr_addr         circular-buffer address inside [id*N, id*N+N-1]
//   i_price           unsigned price
//   o_vol_valid       1-cycle pulse; o_vol_stock/o_sum/o_var_n2 valid
//   o_vol_stock       stock the result belongs to
//   o_sum             sum of the N prices in the window
//   o_var_n2          N*sum(p^2) - (sum p)^2
//   o_window_full     per-stock window-full flags
// ---------------------------------------------------------------------------
module volatility_window_stats #(
    parameter int NUM_STOCKS  = 4,
    parameter int BUFFER_SIZE = 20,
    parameter int DATA_WIDTH  = 32,
    localparam int SIDW = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
    localparam int AW   = $clog2(NUM_STOCKS * BUFFER_SIZE),
    localparam int CW   = $clog2(BUFFER_SIZE + 1),
    localparam int SW   = DATA_WIDTH + CW,
    localparam int QW   = 2 * DATA_WIDTH + CW,
    localparam int VW   = QW + CW
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_wr_valid,
    input  logic [SIDW-1:0]       i_stock_id,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_price,
    output logic                  o_vol_valid,
    output logic [SIDW-1:0]       o_vol_stock,
    output logic [SW-1:0]         o_sum,
    output logic [VW-1:0]         o_var_n2,
    output logic [NUM_STOCKS-1:0] o_window_full
);

    localparam logic [CW-1:0] N_C = CW'(BUFFER_SIZE);

    // Window storage; not reset, the counts decide what is meaningful.
    logic [DATA_WIDTH-1:0] mem [NUM_STOCKS*BUFFER_SIZE];
    logic [DATA_WIDTH-1:0] old_price;

    // Per-stock running state
    logic [SW-1:0] sum_r   [NUM_STOCKS];
    logic [QW-1:0] sumsq_r [NUM_STOCKS];
    logic [CW-1:0] cnt_r   [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] full_r;

    // Stage 1 registers
    logic                  s1_vld;
    logic [SIDW-1:0]       s1_stock;
    logic [AW-1:0]         s1_addr;
    logic [DATA_WIDTH-1:0] s1_price;

    // Stage 2 registers (forwarded post-update values)
    logic            s2_vld;
    logic [SIDW-1:0] s2_stock;
    logic [SW-1:0]   s2_sum;
    logic [QW-1:0]   s2_sumsq;

    // Stage 2 combinational update
    logic          cur_full;
    logic [SW-1:0] new_sum;
    logic [QW-1:0] new_sumsq;
    logic [CW-1:0] new_cnt;

    always_comb begin
        cur_full  = (cnt_r[s1_stock] == N_C);
        // Unsigned modular add-then-subtract; the final value is exact.
        new_sum   = sum_r[s1_stock] + SW'(s1_price)
                    - (cur_full ? SW'(old_price) : '0);
        new_sumsq = sumsq_r[s1_stock] + QW'(s1_price) * QW'(s1_price)
                    - (cur_full ? QW'(old_price) * QW'(old_price) : '0);
        new_cnt   = cur_full ? cnt_r[s1_stock] : cnt_r[s1_stock] + CW'(1);
    end

    // Synchronous read of the evicted price and write of the new one. With
    // BUFFER_SIZE >= 2, the read at E0 and the write of the previous sample
    // of the same stock never target the same address.
    always_ff @(posedge i_clk) begin
        old_price <= mem[i_wr_addr];
        if (i_reset_n && s1_vld)
            mem[s1_addr] <= s1_price;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            s1_vld      <= 1'b0;
            s1_stock    <= '0;
            s1_addr     <= '0;
            s1_price    <= '0;
            s2_vld      <= 1'b0;
            s2_stock    <= '0;
            s2_sum      <= '0;
            s2_sumsq    <= '0;
            o_vol_valid <= 1'b0;
            o_vol_stock <= '0;
            o_sum       <= '0;
            o_var_n2    <= '0;
            full_r      <= '0;
            for (int i = 0; i < NUM_STOCKS; i++) begin
                sum_r[i]   <= '0;
                sumsq_r[i] <= '0;
                cnt_r[i]   <= '0;
            end
        end else begin
            // Stage 1
            s1_vld <= i_wr_valid;
            if (i_wr_valid) begin
                s1_stock <= i_stock_id;
                s1_addr  <= i_wr_addr;
                s1_price <= i_price;
            end

            // Stage 2
            s2_vld <= s1_vld && (new_cnt == N_C);
            if (s1_vld) begin
                sum_r[s1_stock]   <= new_sum;
                sumsq_r[s1_stock] <= new_sumsq;
                cnt_r[s1_stock]   <= new_cnt;
                full_r[s1_stock]  <= (new_cnt == N_C);
                s2_stock          <= s1_stock;
                s2_sum            <= new_sum;
                s2_sumsq          <= new_sumsq;
            end

            // Stage 3; data outputs hold when no result is produced
            o_vol_valid <= s2_vld;
            if (s2_vld) begin
                o_vol_stock <= s2_stock;
                o_sum       <= s2_sum;
                o_var_n2    <= VW'(BUFFER_SIZE) * VW'(s2_sumsq)
                               - VW'(s2_sum) * VW'(s2_sum);
            end
        end
    end

    assign o_window_full = full_r;

endmodule

// File: tb/tb_volatility_window_stats.sv
// ---------------------------------------------------------------------------
// tb_volatility_window_stats
//   Directed and random stimulus for volatility_window_stats (N=4, 4 stocks).
//   The stimulus side pushes expected results into a queue; a monitor pops
//   and compares on every o_vol_valid pulse. Directed phases also compare
//   the last result seen per stock against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_volatility_window_stats;

    localparam int NS   = 4;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int SIDW = 2;
    localparam int AW   = $clog2(NS * N);
    localparam int CW   = $clog2(N + 1);
    localparam int SW   = DW + CW;
    localparam int QW   = 2 * DW + CW;
    localparam int VW   = QW + CW;

    typedef struct {
        int           stock;
        logic [127:0] sum;
        logic [127:0] var_n2;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_valid = 1'b0;
    logic [SIDW-1:0] stock_id = '0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   price = '0;
    logic            vol_valid;
    logic [SIDW-1:0] vol_stock;
    logic [SW-1:0]   sum;
    logic [VW-1:0]   var_n2;
    logic [NS-1:0]   window_full;

    int errors = 0;
    int checks = 0;
    int n_pulses = 0;

    logic [DW-1:0] win [NS][$];
    int            ptr [NS];
    exp_t          exp_q [$];
    logic [127:0]  last_sum [NS];
    logic [127:0]  last_var [NS];

    volatility_window_stats #(
        .NUM_STOCKS(NS), .BUFFER_SIZE(N), .DATA_WIDTH(DW)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_wr_valid(wr_valid),
        .i_stock_id(stock_id), .i_wr_addr(wr_addr), .i_price(price),
        .o_vol_valid(vol_valid), .o_vol_stock(vol_stock), .o_sum(sum),
        .o_var_n2(var_n2), .o_window_full(window_full)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Writes must stay inside the sample's stock region.
    always @(posedge clk) begin
        if (rst_n && wr_valid)
            assert (int'(wr_addr) >= int'(stock_id) * N && int'(wr_addr) < int'(stock_id) * N + N)
            else $error("illegal wr_addr %0d for stock %0d", wr_addr, stock_id);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: compare every result pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && vol_valid) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: stock %0d sum %0d var %0d, expected none",
                         vol_stock, sum, var_n2);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_stock", 128'(vol_stock), 128'(e.stock));
                chk("result_sum",   128'(sum),       e.sum);
                chk("result_var",   128'(var_n2),    e.var_n2);
            end
            last_sum[vol_stock] = 128'(sum);
            last_var[vol_stock] = 128'(var_n2);
        end
    end

    // Reference: recompute the window statistics from scratch.
    function automatic exp_t model_result(input int s);
        exp_t e;
        logic [127:0] sm, sq;
        sm = 0;
        sq = 0;
        for (int i = 0; i < win[s].size(); i++) begin
            sm += 128'(win[s][i]);
            sq += 128'(win[s][i]) * 128'(win[s][i]);
        end
        e.stock  = s;
        e.sum    = sm;
        e.var_n2 = 128'(N) * sq - sm * sm;
        return e;
    endfunction

    task automatic send(input int s, input logic [DW-1:0] p);
        @(negedge clk);
        wr_valid = 1'b1;
        stock_id = SIDW'(s);
        wr_addr  = AW'(s * N + ptr[s]);
        price    = p;
        ptr[s]   = (ptr[s] + 1) % N;
        win[s].push_back(p);
        if (win[s].size() > N) void'(win[s].pop_front());
        if (win[s].size() == N) exp_q.push_back(model_result(s));
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        gap(1);
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        gap(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NS; i++) begin
            win[i].delete();
            ptr[i] = 0;
        end
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            ptr[i] = 0;
            last_sum[i] = 0;
            last_var[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_vol_valid", 128'(vol_valid), 0);
        chk("reset_vol_stock", 128'(vol_stock), 0);
        chk("reset_sum", 128'(sum), 0);
        chk("reset_var", 128'(var_n2), 0);
        chk("reset_window_full", 128'(window_full), 0);

        // 1: four equal prices, one result on the fourth sample
        n_pulses = 0;
        for (int i = 0; i < 4; i++) send(0, 32'd10);
        drain();
        chk("t1_pulses", 128'(n_pulses), 1);
        chk("t1_sum", last_sum[0], 128'd40);
        chk("t1_var", last_var[0], 128'd0);
        chk("t1_window_full", 128'(window_full), 128'b0001);

        // 2: evict a 10 with 14
        send(0, 32'd14);
        drain();
        chk("t2_sum", last_sum[0], 128'd44);
        chk("t2_var", last_var[0], 128'd48);

        // 3: interleave stock0 (100..800) and stock1 (1..8)
        for (int i = 1; i <= 8; i++) begin
            send(0, DW'(100 * i));
            send(1, DW'(i));
        end
        drain();
        chk("t3_sum_s0", last_sum[0], 128'd2600);
        chk("t3_var_s0", last_var[0], 128'd200000);
        chk("t3_sum_s1", last_sum[1], 128'd26);
        chk("t3_var_s1", last_var[1], 128'd20);
        chk("t3_window_full", 128'(window_full), 128'b0011);

        // 4: maximum prices, no wrap
        for (int i = 0; i < 6; i++) send(2, 32'hFFFF_FFFF);
        drain();
        chk("t4_sum", last_sum[2], 128'd17179869180);
        chk("t4_var", last_var[2], 128'd0);
        chk("t4_window_full", 128'(window_full), 128'b0111);

        // 5: reset mid-fill, then a fresh window
        send(3, 32'd7);
        send(3, 32'd8);
        do_reset();
        @(negedge clk);
        chk("t5_reset_window_full", 128'(window_full), 0);
        n_pulses = 0;
        for (int i = 1; i <= 4; i++) send(3, DW'(i));
        drain();
        chk("t5_pulses", 128'(n_pulses), 1);
        chk("t5_sum", last_sum[3], 128'd10);
        chk("t5_var", last_var[3], 128'd20);
        chk("t5_window_full", 128'(window_full), 128'b1000);

        // 6: random stocks, prices and gaps
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) gap(int'($urandom_range(1, 3)));
            send(int'($urandom_range(0, NS - 1)), $urandom);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
